// File: rtl/jts16b_pkg.sv
// Shared types and defaults for the S16B sound-command consumer.
package jts16b_pkg;

  // Single-entry handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,   // nothing latched
    PEND = 2'd1,   // command latched, NMI raised, waiting for the Z80 to read
    CLR  = 2'd2    // read acknowledged, waiting for the mapper to drop obf
  } sndcmd_st_e;

  localparam logic [7:0] CMD_PORT_DEF = 8'h40;
  localparam logic [7:0] STS_PORT_DEF = 8'h80;
  localparam int         NMI_LEN_DEF  = 4;
  localparam int         FIFO_AW_DEF  = 2;

  // Status byte seen by the Z80 on an STS_PORT read
  function automatic logic [7:0] sts_byte(input logic pending, input logic full,
                                          input logic [3:0] cnt);
    return {pending, full, 2'b00, cnt};
  endfunction

endpackage

// File: rtl/jts16b_sndcmd_fifo.sv
// Small synchronous FIFO used to drain the mapper sound latch.
module jts16b_sndcmd_fifo #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];
  assign full    = count == DEPTH;
  assign empty   = count == '0;

  // Pointers wrap naturally; count tracks occupancy so full/empty are unambiguous
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/jts16b_sndcmd.sv
// Z80-side consumer of the 315-5195 sound-command latch.
// Raises NMI when a command arrives, returns it on an I/O read of CMD_PORT,
// reports status on STS_PORT and pulses sndmap_rd to clear the mapper's obf.
// Optional build macro JTS16B_SNDCMD_FIFO_EN replaces the single-entry
// handshake with a FIFO that drains the mapper autonomously.
module jts16b_sndcmd
  import jts16b_pkg::*;
#(
  parameter logic [7:0] CMD_PORT = CMD_PORT_DEF,
  parameter logic [7:0] STS_PORT = STS_PORT_DEF,
  parameter int         NMI_LEN  = NMI_LEN_DEF,
  parameter int         FIFO_AW  = FIFO_AW_DEF
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic [7:0] sndmap_dout,
  input  logic       sndmap_obf,
  output logic       sndmap_rd,
  input  logic [7:0] z80_addr,
  input  logic       z80_iorqn,
  input  logic       z80_rdn,
  input  logic       z80_m1n,
  output logic [7:0] dout,
  output logic       dout_ok,
  output logic       nmin
);

  localparam logic [3:0] NMI_LEN4 = 4'(NMI_LEN);

  logic             rd_act, rd_act_l, rd_start;
  logic             cmd_hit, sts_hit, cmd_start, sts_start;
  logic [7:0]       cmd_r, rd_data;
  logic             nmi_trig;
  logic [3:0]       nmi_cnt;
  logic             q_empty, q_full;
  logic [FIFO_AW:0] q_cnt;

  // I/O read decode; interrupt-acknowledge cycles (M1 low) never match
  assign rd_act    = ~z80_iorqn & ~z80_rdn & z80_m1n;
  assign cmd_hit   = z80_addr == CMD_PORT;
  assign sts_hit   = z80_addr == STS_PORT;
  assign rd_start  = rd_act & ~rd_act_l;
  assign cmd_start = rd_start & cmd_hit;
  assign sts_start = rd_start & sts_hit;
  assign dout_ok   = rd_act & (cmd_hit | sts_hit);

  // Previous-cycle access flag so a long access counts as one read
  always_ff @(posedge clk) begin
    if (rst) rd_act_l <= 1'b0;
    else     rd_act_l <= rd_act;
  end

  // Read data is captured once at access start and held until the next one
  always_ff @(posedge clk) begin
    if (rst)            dout <= 8'h00;
    else if (sts_start) dout <= sts_byte(~q_empty, q_full, 4'(q_cnt));
    else if (cmd_start) dout <= rd_data;
  end

  // NMI pulse: reload on trigger (no gap on retrigger), count down on cen
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_cnt <= 4'd0;
      nmin    <= 1'b1;
    end else if (nmi_trig) begin
      nmi_cnt <= NMI_LEN4;
      nmin    <= 1'b0;
    end else if (cen && nmi_cnt != 4'd0) begin
      nmi_cnt <= nmi_cnt - 4'd1;
      nmin    <= nmi_cnt == 4'd1;
    end
  end

`ifdef JTS16B_SNDCMD_FIFO_EN

  logic       push, pop;
  logic [7:0] head;

  // Drain the mapper whenever there is room; skip the cycle right after a
  // pulse so the mapper's obf has time to drop before we look again
  assign push     = sndmap_obf & ~q_full & ~sndmap_rd;
  assign pop      = cmd_start & ~q_empty;
  assign rd_data  = q_empty ? cmd_r : head;
  assign nmi_trig = (push & q_empty) |
                    (pop & ((q_cnt > {{FIFO_AW{1'b0}}, 1'b1}) | push));

  jts16b_sndcmd_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sndmap_dout),
    .head  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_cnt)
  );

  // Mapper acknowledge and last-popped byte for reads on an empty FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      sndmap_rd <= 1'b0;
      cmd_r     <= 8'h00;
    end else begin
      sndmap_rd <= push;
      if (pop) cmd_r <= head;
    end
  end

`else

  sndcmd_st_e st;

  assign q_empty  = st != PEND;
  assign q_full   = 1'b0;
  assign q_cnt    = {{FIFO_AW{1'b0}}, st == PEND};
  assign rd_data  = cmd_r;
  assign nmi_trig = (st == IDLE) & sndmap_obf;

  // Single-entry handshake: obf stays set until the Z80 actually reads,
  // so the 68000 sees the latch busy for the whole time
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cmd_r     <= 8'h00;
      sndmap_rd <= 1'b0;
    end else begin
      sndmap_rd <= 1'b0;
      case (st)
        IDLE: if (sndmap_obf) begin
          cmd_r <= sndmap_dout;
          st    <= PEND;
        end
        PEND: if (cmd_start) begin
          sndmap_rd <= 1'b1;
          st        <= CLR;
        end else if (sndmap_obf) begin
          cmd_r <= sndmap_dout;     // keep the newest byte on overwrite
        end
        CLR: if (!sndmap_obf) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_jts16b_sndcmd.sv
// Bench for jts16b_sndcmd (default single-entry build).
module tb_jts16b_sndcmd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [7:0] sndmap_dout = 8'h00;
  logic       sndmap_obf = 1'b0;
  logic       sndmap_rd;
  logic [7:0] z80_addr = 8'h00;
  logic       z80_iorqn = 1'b1;
  logic       z80_rdn = 1'b1;
  logic       z80_m1n = 1'b1;
  logic [7:0] dout;
  logic       dout_ok;
  logic       nmin;

  always #5 clk = ~clk;

  jts16b_sndcmd dut (
    .rst(rst), .clk(clk), .cen(cen),
    .sndmap_dout(sndmap_dout), .sndmap_obf(sndmap_obf), .sndmap_rd(sndmap_rd),
    .z80_addr(z80_addr), .z80_iorqn(z80_iorqn), .z80_rdn(z80_rdn), .z80_m1n(z80_m1n),
    .dout(dout), .dout_ok(dout_ok), .nmin(nmin)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Environment: 68000 write requests and a clocked mapper latch
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_q = 1'b0;
  bit         rnd_cen = 1'b0;

  // Observed-behaviour counters for the directed checks
  int  nmi_falls = 0, nmi_lowcen = 0, rd_pulses = 0;
  logic prev_nmin = 1'b1;

  // Reference model: a mailbox that is either empty, holding an unread
  // command, or waiting for the mapper to acknowledge a read
  bit         mbox_full = 0, ack_out = 0, m_prev_act = 0, m_rd = 0;
  logic [7:0] m_cmd = 8'h00, m_dout = 8'h00;
  int         m_nmi = 0;

  task automatic model_step();
    bit act, start, cs, ss, fired;
    act   = !z80_iorqn && !z80_rdn && z80_m1n;
    start = act && !m_prev_act;
    cs    = start && z80_addr == 8'h40;
    ss    = start && z80_addr == 8'h80;
    if (rst) begin
      mbox_full = 0; ack_out = 0; m_prev_act = 0; m_rd = 0;
      m_cmd = 8'h00; m_dout = 8'h00; m_nmi = 0;
      return;
    end
    m_prev_act = act;
    if (ss)      m_dout = mbox_full ? 8'h81 : 8'h00;
    else if (cs) m_dout = m_cmd;
    m_rd  = 0;
    fired = 0;
    if (mbox_full) begin
      if (cs) begin
        m_rd = 1; mbox_full = 0; ack_out = 1;
      end else if (sndmap_obf) m_cmd = sndmap_dout;
    end else if (ack_out) begin
      if (!sndmap_obf) ack_out = 0;
    end else if (sndmap_obf) begin
      m_cmd = sndmap_dout; mbox_full = 1; fired = 1;
    end
    if (fired) m_nmi = 4;
    else if (cen && m_nmi > 0) m_nmi--;
  endtask

  // One clock: model, compare, then drive the next inputs away from the edge
  task automatic tick();
    bit cen_edge;
    @(posedge clk);
    cen_edge = cen;
    model_step();
    #1;
    check("sndmap_rd", sndmap_rd, m_rd);
    check("nmin", nmin, m_nmi == 0);
    check("dout", dout, m_dout);
    check("dout_ok", dout_ok,
          !z80_iorqn && !z80_rdn && z80_m1n && (z80_addr == 8'h40 || z80_addr == 8'h80));
    if (!prev_nmin && cen_edge) nmi_lowcen++;
    if (prev_nmin && !nmin) nmi_falls++;
    if (sndmap_rd) rd_pulses++;
    prev_nmin = nmin;
    if (rd_q) sndmap_obf = 1'b0;
    else if (wr_req) begin
      sndmap_obf = 1'b1; sndmap_dout = wr_data; wr_req = 1'b0;
    end
    rd_q = sndmap_rd;
    cen = rnd_cen ? 1'($urandom_range(0, 1)) : ~cen;
  endtask

  task automatic write(input logic [7:0] d);
    wr_req = 1'b1; wr_data = d;
    tick();
  endtask

  task automatic io_read(input logic [7:0] a, input int len);
    z80_addr = a; z80_iorqn = 1'b0; z80_rdn = 1'b0; z80_m1n = 1'b1;
    repeat (len) tick();
    z80_iorqn = 1'b1; z80_rdn = 1'b1;
    tick();
  endtask

  task automatic clr_cnt();
    nmi_falls = 0; nmi_lowcen = 0; rd_pulses = 0;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_nmin", nmin, 1'b1);
    check("reset_rd", sndmap_rd, 1'b0);
    check("reset_dout", dout, 8'h00);
    check("reset_dout_ok", dout_ok, 1'b0);
    rst = 1'b0;
    tick();

    // Basic command delivery
    clr_cnt();
    write(8'h5A);
    repeat (14) tick();
    check("basic_nmi_falls", nmi_falls, 1);
    check("basic_nmi_len", nmi_lowcen, 4);
    io_read(8'h80, 2);
    check("sts_pending", dout, 8'h81);
    clr_cnt();
    io_read(8'h40, 2);
    check("basic_dout", dout, 8'h5A);
    check("basic_rd_pulses", rd_pulses, 1);
    repeat (4) tick();
    io_read(8'h80, 1);
    check("sts_idle", dout, 8'h00);

    // Long access: one acknowledge only
    write(8'h5A);
    repeat (10) tick();
    clr_cnt();
    io_read(8'h40, 10);
    check("long_rd_pulses", rd_pulses, 1);
    check("long_dout", dout, 8'h5A);

    // Overwrite before the Z80 reads
    repeat (4) tick();
    clr_cnt();
    write(8'h11);
    repeat (3) tick();
    write(8'h22);
    repeat (14) tick();
    check("ovw_nmi_falls", nmi_falls, 1);
    io_read(8'h40, 2);
    check("ovw_dout", dout, 8'h22);

    // Reset while a command is pending and obf is still set
    repeat (4) tick();
    write(8'h33);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    clr_cnt();
    repeat (12) tick();
    check("rst_nmi_falls", nmi_falls, 1);
    check("rst_no_rd", rd_pulses, 0);
    io_read(8'h40, 2);
    check("rst_dout", dout, 8'h33);

    // Stale read while idle
    repeat (4) tick();
    clr_cnt();
    io_read(8'h40, 3);
    check("stale_dout", dout, 8'h33);
    check("stale_no_rd", rd_pulses, 0);

    // Interrupt-acknowledge cycle is not decoded
    write(8'h44);
    repeat (3) tick();
    clr_cnt();
    z80_addr = 8'h40; z80_iorqn = 1'b0; z80_rdn = 1'b0; z80_m1n = 1'b0;
    tick();
    check("inta_dout_ok", dout_ok, 1'b0);
    repeat (2) tick();
    z80_iorqn = 1'b1; z80_rdn = 1'b1; z80_m1n = 1'b1;
    tick();
    check("inta_no_rd", rd_pulses, 0);
    io_read(8'h40, 2);
    check("inta_dout", dout, 8'h44);

    // Randomized traffic against the model
    rnd_cen = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1; wr_data = 8'($urandom);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: repeat ($urandom_range(1, 4)) tick();
        6, 7: io_read(8'h40, $urandom_range(1, 4));
        8:    io_read($urandom_range(0, 1) ? 8'h80 : 8'($urandom), $urandom_range(1, 3));
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            z80_addr = 8'h40; z80_iorqn = 1'b0; z80_rdn = 1'b0; z80_m1n = 1'b0;
            repeat (2) tick();
            z80_iorqn = 1'b1; z80_rdn = 1'b1; z80_m1n = 1'b1;
            tick();
          end else begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
          end
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jts16b_sndcmd.md
Name: jts16b_sndcmd

Overview:
- Z80-side consumer of the 315-5195 mapper's sound-command latch (mapper register 3).
- The main 68000 writes the latch, and the mapper raises sndmap_obf.
- This block raises the Z80 NMI, returns the command byte on a Z80 I/O read, and pulses sndmap_rd to clear obf.
- It sits between the mapper and the sound CPU's I/O decoder in the S16B sound subsystem.

Parameters:
- CMD_PORT, 8'h40, Z80 I/O address (A[7:0]) returning the command byte.
- STS_PORT, 8'h80, Z80 I/O address returning status.
- NMI_LEN, 4, NMI low-pulse length in cen cycles (1..15).
- FIFO_AW, 2, FIFO address width when the optional feature is on (depth = 2^FIFO_AW).

Ports:
- rst  in  1  synchronous reset, active high
- clk  in  1  system clock
- cen  in  1  Z80 clock enable
- sndmap_dout  in  8  mapper latch value
- sndmap_obf  in  1  mapper latch full
- sndmap_rd  out  1  one-clk pulse; clears obf in the mapper
- z80_addr  in  8  Z80 A[7:0]
- z80_iorqn  in  1  Z80 IORQ_n
- z80_rdn  in  1  Z80 RD_n
- z80_m1n  in  1  Z80 M1_n
- dout  out  8  read data to the Z80 data-bus mux
- dout_ok  out  1  high while dout is driven (CMD or STS read in progress)
- nmin  out  1  Z80 NMI_n

Behaviour:
- Reset values: sndmap_rd=0, dout=0, dout_ok=0, nmin=1. State=IDLE, latched byte=0, NMI counter=0, FIFO empty.
- I/O read detect: rd_act = ~iorqn & ~rdn & m1n.
  - CMD read starts on the first clk where rd_act & addr==CMD_PORT, with rd_act low on the previous clk. Exactly one pop per Z80 access, regardless of access length.
  - STS read uses STS_PORT.
  - INTA cycles (m1n=0) are never decoded.
- dout_ok follows rd_act & port hit combinationally. dout is registered at read start and held until the next read start.
- STS read returns {pending, fifo_full, 2'b0, count[3:0]}.
  - Non-FIFO build: count = pending.
  - pending = a command is waiting.
- FSM (non-FIFO build):
  - IDLE: obf==1 → capture sndmap_dout into cmd_r, start NMI pulse, go PEND. Do not pulse sndmap_rd yet; obf stays set so the main CPU sees busy.
  - PEND: CMD read start → dout<=cmd_r, sndmap_rd=1 for exactly one clk, go CLR.
  - CLR: wait for obf==0, then go IDLE. If obf is still 1 after 2 clks, the main CPU rewrote on the same edge; the mapper's rd clear wins, so this state only exits on obf==0.
- A CMD read in IDLE returns the last cmd_r (stale), pulses nothing, and leaves state unchanged.
- NMI:
  - On trigger, nmin=0 for NMI_LEN cen cycles, then 1. The counter decrements on cen only.
  - A re-trigger while the pulse is active restarts the count but does not create a gap (edge semantics preserved: one Z80 NMI).
- cmd_r refresh: if obf rises while in PEND (a new write without a clear), cmd_r is re-sampled every clk so the newest byte is returned. No extra NMI is generated.
- Reset mid-operation returns to IDLE immediately. If obf is still set after reset, a fresh NMI is issued on the next clk.

Optional Feature:
- Macro: JTS16B_SNDCMD_FIFO_EN.
- With the macro, the block drains the mapper autonomously:
  - Whenever obf & ~full & sndmap_rd was low on the previous clk, it pushes sndmap_dout and pulses sndmap_rd for one clk.
  - When full, obf is left set, which back-pressures the 68000.
  - A CMD read pops the head. A read on empty returns the last popped byte and leaves the count unchanged.
  - NMI triggers on an empty→non-empty push, and after each pop that leaves the FIFO non-empty.
  - Simultaneous push and pop keeps the count constant. Pointers wrap mod 2^FIFO_AW.
- Without the macro: single-entry FSM only, and the FIFO logic is absent.

Decomposition:
- jts16b_pkg holds the state encoding (IDLE/PEND/CLR) and the default port constants.
- One sub-module, jts16b_sndcmd_fifo (sync FIFO, push/pop/full/empty/count), instantiated only under JTS16B_SNDCMD_FIFO_EN.

Test Plan:
- Basic: obf rises with dout=8'h5A → nmin low for 4 cen cycles. IN 0x40 → dout=8'h5A, one sndmap_rd pulse; obf drops → IDLE.
- Long read: RD held low for 10 clks → exactly one sndmap_rd pulse; dout stable at 8'h5A throughout.
- Overwrite: 8'h11 then 8'h22 before any Z80 read → one NMI only; IN 0x40 returns 8'h22.
- Status: with a command pending, IN 0x80 returns 8'h81. After the read and obf clear, it returns 8'h00.
- Reset: rst asserted in PEND with obf held → after release, nmin pulses again and sndmap_rd=0 until a read occurs.
- FIFO build (FIFO_AW=2): five back-to-back writes 1..5 → four rd pulses; obf stays set on the 5th. Pops return 1,2,3,4, then 5 is drained in, with an NMI after each non-emptying pop.
